// File: rtl/bcd_running_total_pkg.sv
// Shared definitions for the BCD running-total accumulator: FSM states and
// the decimal constants used by both the digit adder and the control path.
package bcd_running_total_pkg;

    localparam int BCD_MAX_SUM = 19;
    localparam int BCD_RADIX   = 10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_running_total_digit_add.sv
// One-digit BCD adder with carry: binary add followed by add-6 correction.
// Purely combinational; the accumulator time-multiplexes a single instance.
module bcd_digit_add
    import bcd_running_total_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);

    logic [4:0] raw;

    assign raw = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, c_i};
    assign c_o = (raw >= 5'(BCD_RADIX));
    // Adding 6 skips the six unused 4-bit codes, so the low nibble lands on raw-10.
    assign s_o = c_o ? (raw[3:0] + 4'd6) : raw[3:0];

endmodule

// File: rtl/bcd_running_total.sv
// NUM_DIGITS-digit BCD running total fed by the adder stage's binary sum.
// Each synchronized add_req edge adds sum_in, one decimal digit per cycle.
module bcd_running_total
    import bcd_running_total_pkg::*;
#(
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [4:0]              sum_in_i,
    input  logic                    add_req_i,
    input  logic                    clr_i,
    output logic [4*NUM_DIGITS-1:0] total_bcd_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    ovf_o,
    output logic                    err_o
);

    localparam int TW    = 4 * NUM_DIGITS;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [1:0] sync_q;
    logic       req_prev_q;
    logic       req_rise;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q     <= 2'b00;
            req_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], add_req_i};
            req_prev_q <= sync_q[1];
        end
    end

    assign req_rise = sync_q[1] & ~req_prev_q;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       op0_q, op0_d;
    logic             op1_q, op1_d;
    logic             carry_q, carry_d;
    logic [TW-1:0]    total_q, total_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;

    logic [3:0] cur_digit, op_digit, sum_digit;
    logic       sum_carry;
    logic [4:0] sum_minus_radix;

    always_comb begin
        cur_digit = total_q[4*idx_q +: 4];
        if (idx_q == '0)
            op_digit = op0_q;
        else if (idx_q == IDX_W'(1))
            op_digit = {3'b000, op1_q};
        else
            op_digit = 4'd0;
    end

    bcd_digit_add u_digit_add (
        .a_i (cur_digit),
        .b_i (op_digit),
        .c_i (carry_q),
        .s_o (sum_digit),
        .c_o (sum_carry)
    );

    assign sum_minus_radix = sum_in_i - 5'(BCD_RADIX);

    // NOTE: every variable gets its default first, so no path through the block can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op0_d   = op0_q;
        op1_d   = op1_q;
        carry_d = carry_q;
        total_d = total_q;
        ovf_d   = ovf_q;
        err_d   = err_q;

        if (clr_i) begin
            state_d = S_IDLE;
            idx_d   = '0;
            carry_d = 1'b0;
            total_d = '0;
            ovf_d   = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_rise) begin
                        if (sum_in_i > 5'(BCD_MAX_SUM)) begin
                            err_d = 1'b1;
                        end else begin
                            op1_d   = (sum_in_i >= 5'(BCD_RADIX));
                            op0_d   = op1_d ? sum_minus_radix[3:0] : sum_in_i[3:0];
                            carry_d = 1'b0;
                            idx_d   = '0;
                            state_d = S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    total_d[4*idx_q +: 4] = sum_digit;
                    carry_d               = sum_carry;
                    if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                        state_d = S_DONE;
                        if (sum_carry)
                            ovf_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            op0_q   <= 4'd0;
            op1_q   <= 1'b0;
            carry_q <= 1'b0;
            total_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op0_q   <= op0_d;
            op1_q   <= op1_d;
            carry_q <= carry_d;
            total_q <= total_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign total_bcd_o = total_q;
    assign busy_o      = (state_q == S_ADD);
    assign done_o      = (state_q == S_DONE);
    assign ovf_o       = ovf_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_bcd_running_total.sv
// Scoreboard bench for bcd_running_total: a decimal model predicts each
// completed accumulation; a monitor checks the total whenever done pulses.
module tb_bcd_running_total;

    localparam int N     = 3;
    localparam int LIMIT = 1000;

    logic           clk_i = 1'b0;
    logic           rst_i;
    logic [4:0]     sum_in_i;
    logic           add_req_i;
    logic           clr_i;
    logic [4*N-1:0] total_bcd_o;
    logic           busy_o;
    logic           done_o;
    logic           ovf_o;
    logic           err_o;

    bcd_running_total #(.NUM_DIGITS(N)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .sum_in_i    (sum_in_i),
        .add_req_i   (add_req_i),
        .clr_i       (clr_i),
        .total_bcd_o (total_bcd_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .ovf_o       (ovf_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4*N-1:0] total;
        logic           ovf;
    } exp_t;

    exp_t sb[$];
    int   n_checks   = 0;
    int   n_pass     = 0;
    int   done_count = 0;
    int   m_total    = 0;
    bit   m_ovf      = 1'b0;
    bit   m_err      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r;
        int x;
        x = v;
        for (int k = 0; k < N; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic void model_add(input int s);
        exp_t e;
        m_total = m_total + s;
        if (m_total >= LIMIT) begin
            m_total = m_total - LIMIT;
            m_ovf   = 1'b1;
        end
        e.total = to_bcd(m_total);
        e.ovf   = m_ovf;
        sb.push_back(e);
    endfunction

    function automatic void model_clear();
        m_total = 0;
        m_ovf   = 1'b0;
        m_err   = 1'b0;
        sb.delete();
    endfunction

    // Monitor: every done pulse must match the oldest outstanding prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && done_o) begin
                done_count++;
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_total", 32'(total_bcd_o), 32'(e.total));
                    check("done_ovf", 32'(ovf_o), 32'(e.ovf));
                end
            end
        end
    end

    task automatic raise_req(input logic [4:0] s);
        sum_in_i = s;
        @(posedge clk_i);
        #($urandom_range(1, 8));
        add_req_i = 1'b1;
    endtask

    task automatic wait_busy(input string name);
        int waited;
        waited = 0;
        while (!busy_o && waited < 12) begin
            @(negedge clk_i);
            waited++;
        end
        check(name, 32'(busy_o), 32'd1);
    endtask

    task automatic add_legal(input logic [4:0] s);
        int busy_len;
        raise_req(s);
        model_add(int'(s));
        wait_busy("accept");
        busy_len = 0;
        while (busy_o && busy_len < 10) begin
            busy_len++;
            @(negedge clk_i);
        end
        check("busy_cycles", 32'(busy_len), 32'(N));
        check("done_after_busy", 32'(done_o), 32'd1);
        add_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("err_flag", 32'(err_o), 32'(m_err));
    endtask

    task automatic add_bad(input logic [4:0] s);
        bit busy_seen;
        int d0;
        d0 = done_count;
        busy_seen = 1'b0;
        raise_req(s);
        repeat (8) begin
            @(negedge clk_i);
            busy_seen |= busy_o;
        end
        m_err = 1'b1;
        check("bad_no_busy", 32'(busy_seen), 32'd0);
        check("bad_no_done", 32'(done_count - d0), 32'd0);
        check("bad_err", 32'(err_o), 32'd1);
        check("bad_total", 32'(total_bcd_o), 32'(to_bcd(m_total)));
        add_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
    endtask

    task automatic do_clear();
        @(negedge clk_i);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        model_clear();
        check("clr_total", 32'(total_bcd_o), 32'd0);
        check("clr_ovf", 32'(ovf_o), 32'd0);
        check("clr_err", 32'(err_o), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_i     = 1'b1;
        sum_in_i  = 5'd0;
        add_req_i = 1'b0;
        clr_i     = 1'b0;
        repeat (3) @(posedge clk_i);
        #2 rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_total", 32'(total_bcd_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_ovf", 32'(ovf_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);

        add_legal(5'd17);
        check("total_017", 32'(total_bcd_o), 32'h017);
        add_legal(5'd19);
        check("total_036", 32'(total_bcd_o), 32'h036);
        check("ovf_036", 32'(ovf_o), 32'd0);

        do_clear();
        for (int i = 0; i < 52; i++) add_legal(5'd19);
        check("total_988", 32'(total_bcd_o), 32'h988);
        add_legal(5'd7);
        check("total_995", 32'(total_bcd_o), 32'h995);
        add_legal(5'd9);
        check("total_004", 32'(total_bcd_o), 32'h004);
        check("ovf_wrap", 32'(ovf_o), 32'd1);
        add_legal(5'd3);
        check("ovf_sticky", 32'(ovf_o), 32'd1);

        add_bad(5'd20);
        check("bad_total_007", 32'(total_bcd_o), 32'h007);
        do_clear();

        // A second request edge that lands while the add is running must be dropped.
        d0 = done_count;
        sum_in_i = 5'd5;
        model_add(5);
        @(posedge clk_i);
        #3 add_req_i = 1'b1;
        repeat (2) @(negedge clk_i);
        add_req_i = 1'b0;
        wait_busy("dbl_accept");
        add_req_i = 1'b1;
        repeat (12) @(negedge clk_i);
        add_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("dbl_total", 32'(total_bcd_o), 32'h005);
        check("dbl_one_done", 32'(done_count - d0), 32'd1);

        // Asynchronous reset in the middle of an add.
        raise_req(5'd9);
        wait_busy("rst_mid_accept");
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("amid_total", 32'(total_bcd_o), 32'd0);
        check("amid_busy", 32'(busy_o), 32'd0);
        check("amid_done", 32'(done_o), 32'd0);
        add_req_i = 1'b0;
        model_clear();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Synchronous clear in the middle of an add.
        add_legal(5'd8);
        d0 = done_count;
        raise_req(5'd9);
        wait_busy("clr_mid_accept");
        @(negedge clk_i);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        model_clear();
        check("cmid_total", 32'(total_bcd_o), 32'd0);
        check("cmid_busy", 32'(busy_o), 32'd0);
        repeat (8) @(negedge clk_i);
        add_req_i = 1'b0;
        check("cmid_no_done", 32'(done_count - d0), 32'd0);
        check("cmid_total_held", 32'(total_bcd_o), 32'd0);
        repeat (3) @(negedge clk_i);

        // Long hold: exactly one accumulation.
        d0 = done_count;
        model_add(4);
        raise_req(5'd4);
        repeat (50) @(negedge clk_i);
        add_req_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("hold_one_done", 32'(done_count - d0), 32'd1);
        check("hold_total", 32'(total_bcd_o), 32'h004);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] s;
            s = 5'($urandom_range(0, 23));
            if ($urandom_range(0, 9) == 0)
                do_clear();
            else if (s > 5'd19)
                add_bad(s);
            else
                add_legal(s);
            check("rand_total", 32'(total_bcd_o), 32'(to_bcd(m_total)));
        end

        repeat (5) @(negedge clk_i);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
